vector_scalar_reduce: RTL

VECTOR_SCALAR_REDUCE -- requirements
Module: vector_scalar_reduce

---
 rtl/lebug_pkg.sv | 40 ++++
 rtl/vector_scalar_reduce_adder_tree.sv | 56 +++++
 rtl/vector_scalar_reduce.sv | 123 ++++++++++++
 3 files changed

// File: rtl/lebug_pkg.sv
// ----------------------------------------------------------------------------
// lebug_pkg
// Shared types and helpers for vector_scalar_reduce.
//   reduce_op_t  : operation selected per vector (PASS / SUM / ACC, 3 reserved)
//   sideband_t   : per-vector control carried alongside the data pipeline
//   calc_latency : input-to-output latency in cycles for an N-lane reducer
//   normalize_op : folds the reserved encoding onto OP_PASS
// ----------------------------------------------------------------------------
package lebug_pkg;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_SUM  = 2'd1,
        OP_ACC  = 2'd2,
        OP_RSVD = 2'd3
    } reduce_op_t;

    typedef struct packed {
        logic       valid;
        logic       eof;
        reduce_op_t op;
    } sideband_t;

    // log2(N) adder-tree stages plus one output stage.
    function automatic int calc_latency(input int n);
        return $clog2(n) + 1;
    endfunction

    // The reserved encoding behaves exactly like a pass-through.
    function automatic reduce_op_t normalize_op(input logic [1:0] op);
        if (op == OP_SUM) begin
            return OP_SUM;
        end
        if (op == OP_ACC) begin
            return OP_ACC;
        end
        return OP_PASS;
    endfunction

endpackage

// File: rtl/vector_scalar_reduce_adder_tree.sv
// ----------------------------------------------------------------------------
// adder_tree
// Registered binary adder tree: sums N lanes of DATA_WIDTH bits in $clog2(N)
// clock cycles. Each adder wraps modulo 2^DATA_WIDTH.
//   clk, rst : clock, synchronous active-high reset
//   valid_i  : data_i is valid this cycle
//   data_i   : N packed lanes, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   valid_o  : valid_i delayed by $clog2(N) cycles
//   sum_o    : lane sum of the vector that entered $clog2(N) cycles earlier
// ----------------------------------------------------------------------------
module adder_tree #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic [N*DATA_WIDTH-1:0] data_i,
    output logic                    valid_o,
    output logic [DATA_WIDTH-1:0]   sum_o
);
    localparam int STAGES = $clog2(N);

    // Level 0 is the raw input; level gi holds N >> gi partial sums.
    genvar gi;
    generate
        for (gi = 0; gi <= STAGES; gi++) begin : g_lvl
            localparam int NODES = N >> gi;
            logic [NODES*DATA_WIDTH-1:0] lvl_sum;
            logic                        lvl_vld;

            if (gi == 0) begin : g_leaf
                assign lvl_sum = data_i;
                assign lvl_vld = valid_i;
            end else begin : g_node
                always_ff @(posedge clk) begin
                    if (rst) begin
                        lvl_sum <= '0;
                        lvl_vld <= 1'b0;
                    end else begin
                        lvl_vld <= g_lvl[gi-1].lvl_vld;
                        for (int k = 0; k < NODES; k++) begin
                            lvl_sum[k*DATA_WIDTH +: DATA_WIDTH] <=
                                g_lvl[gi-1].lvl_sum[(2*k)*DATA_WIDTH +: DATA_WIDTH] +
                                g_lvl[gi-1].lvl_sum[(2*k+1)*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
            end
        end
    endgenerate

    assign sum_o   = g_lvl[STAGES].lvl_sum;
    assign valid_o = g_lvl[STAGES].lvl_vld;

endmodule

// File: rtl/vector_scalar_reduce.sv
// ----------------------------------------------------------------------------
// vector_scalar_reduce
// Per-vector pass-through, lane summation, or frame accumulation with a fixed
// latency of $clog2(N)+1 cycles regardless of operation. No backpressure.
//   clk, rst   : clock, synchronous active-high reset
//   valid_in   : vector_in / eof_in / op_in valid this cycle
//   eof_in     : last vector of the frame
//   op_in      : reduce_op_t (PASS, SUM, ACC; 3 acts as PASS)
//   vector_in  : N packed lanes of DATA_WIDTH bits
//   valid_out  : vector_out valid this cycle
//   eof_out    : frame end, aligned with valid_out
//   vector_out : pass-through lanes, or result in lane 0 with other lanes zero
// ----------------------------------------------------------------------------
module vector_scalar_reduce
    import lebug_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic                    eof_in,
    input  logic [1:0]              op_in,
    input  logic [N*DATA_WIDTH-1:0] vector_in,
    output logic                    valid_out,
    output logic                    eof_out,
    output logic [N*DATA_WIDTH-1:0] vector_out
);
    localparam int STAGES  = $clog2(N);
    localparam int LATENCY = calc_latency(N);

    generate
        if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
            $error("vector_scalar_reduce: N must be a power of two >= 2");
        end
    endgenerate

    // Sideband shift register: entry STAGES-1 lines up with the tree result,
    // entry LATENCY-1 lines up with the output register.
    sideband_t               sb_q   [LATENCY];
    // Raw vector delayed to line up with the tree result for OP_PASS.
    logic [N*DATA_WIDTH-1:0] pass_q [STAGES];

    logic                    tree_valid;
    logic [DATA_WIDTH-1:0]   tree_sum;
    logic [DATA_WIDTH-1:0]   acc_q, acc_d, acc_total;
    logic [N*DATA_WIDTH-1:0] vec_out_q, vec_out_d;

    adder_tree #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tree (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_in),
        .data_i  (vector_in),
        .valid_o (tree_valid),
        .sum_o   (tree_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            // Control is zeroed on bubbles so a stray eof_in never travels.
            sb_q[0].valid <= valid_in;
            sb_q[0].eof   <= valid_in & eof_in;
            sb_q[0].op    <= valid_in ? normalize_op(op_in) : OP_PASS;
            for (int i = 1; i < LATENCY; i++) begin
                sb_q[i] <= sb_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pass_q[0] <= vector_in;
        for (int i = 1; i < STAGES; i++) begin
            pass_q[i] <= pass_q[i-1];
        end
    end

    // Output stage: the accumulator only moves for valid OP_ACC vectors, so
    // PASS/SUM vectors and bubbles leave a running frame untouched.
    always_comb begin
        acc_total = acc_q + tree_sum;
        acc_d     = acc_q;
        vec_out_d = '0;
        if (tree_valid) begin
            case (sb_q[STAGES-1].op)
                OP_SUM: begin
                    vec_out_d[DATA_WIDTH-1:0] = tree_sum;
                end
                OP_ACC: begin
                    vec_out_d[DATA_WIDTH-1:0] = acc_total;
                    acc_d = sb_q[STAGES-1].eof ? '0 : acc_total;
                end
                default: begin
                    vec_out_d = pass_q[STAGES-1];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            vec_out_q <= '0;
        end else begin
            acc_q     <= acc_d;
            vec_out_q <= vec_out_d;
        end
    end

    // Mid-frame ACC vectors are absorbed; eof is only ever set on valid entries.
    assign valid_out  = sb_q[LATENCY-1].valid &
                        ~((sb_q[LATENCY-1].op == OP_ACC) & ~sb_q[LATENCY-1].eof);
    assign eof_out    = sb_q[LATENCY-1].eof;
    assign vector_out = vec_out_q;

endmodule
